synchronous_fifo: RTL and testbench

//   Single-clock first-in/first-out buffer with a power-of-two depth.

---
 rtl/synchronous_fifo_pkg.sv | 14 +
 rtl/synchronous_fifo_mem.sv | 55 +++++
 rtl/synchronous_fifo.sv | 86 ++++++++
 tb/tb_synchronous_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/synchronous_fifo_pkg.sv
// +----------------------------------------------------------------------+
// | synchronous_fifo_pkg : shared defaults for the single-clock FIFO     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package synchronous_fifo_pkg;

  localparam int unsigned DEFAULT_DEPTH      = 8;
  localparam int unsigned DEFAULT_DATA_WIDTH = 6;

endpackage : synchronous_fifo_pkg

`default_nettype wire

// File: rtl/synchronous_fifo_mem.sv
// +----------------------------------------------------------------------+
// | synchronous_fifo_mem : DEPTH x DATA_WIDTH register array with a      |
// |                        synchronous write port and registered read    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module synchronous_fifo_mem
  import synchronous_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_BITS  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage has no reset: only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule : synchronous_fifo_mem

`default_nettype wire

// File: rtl/synchronous_fifo.sv
// +----------------------------------------------------------------------+
// | synchronous_fifo : single-clock FIFO with FULL/EMPTY flags and       |
// |                    exposed wrap-bit pointers                         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module synchronous_fifo
  import synchronous_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic                           rd_en,
  output logic                           FULL,
  output logic                           EMPTY,
  input  logic [DATA_WIDTH-1:0]          data_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [$clog2(DEPTH):0]         wr_ptr,
  output logic [$clog2(DEPTH):0]         rd_ptr
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);

  logic [PTR_BITS:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_BITS:0] rd_ptr_d, rd_ptr_q;
  logic              wr_accept;
  logic              rd_accept;
  logic              full;
  logic              empty;

  // Extra MSB distinguishes a full pass from an empty buffer at equal indices.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                 (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + {{PTR_BITS{1'b0}}, 1'b1};
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + {{PTR_BITS{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  synchronous_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (PTR_BITS)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[PTR_BITS-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_q[PTR_BITS-1:0]),
    .rd_data (data_out)
  );

  assign FULL   = full;
  assign EMPTY  = empty;
  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;

endmodule : synchronous_fifo

`default_nettype wire

// File: tb/tb_synchronous_fifo.sv
// +----------------------------------------------------------------------+
// | tb_synchronous_fifo : directed self-checking bench for the FIFO      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_synchronous_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic       full_o;
  logic       empty_o;
  logic [5:0] data_in;
  logic [5:0] data_out;
  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;

  int checks = 0;
  int errors = 0;

  synchronous_fifo #(
    .DEPTH      (8),
    .DATA_WIDTH (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .FULL     (full_o),
    .EMPTY    (empty_o),
    .data_in  (data_in),
    .data_out (data_out),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fill_words [8];
  logic [5:0] full_words [3];
  logic [5:0] exp_rd     [10];

  initial begin
    fill_words = '{6'h2A, 6'h15, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
    full_words = '{6'h33, 6'h07, 6'h3F};
    exp_rd     = '{6'h2A, 6'h15, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h31, 6'h32};

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    #1;
    check("async_reset_wr_ptr", 32'(wr_ptr), 32'h0);
    check("async_reset_empty",  32'(empty_o), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_wr_ptr",   32'(wr_ptr),   32'h0);
    check("reset_rd_ptr",   32'(rd_ptr),   32'h0);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_empty",    32'(empty_o),  32'h1);
    check("reset_full",     32'(full_o),   32'h0);

    // Read while empty is ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_rd_rd_ptr",   32'(rd_ptr),   32'h0);
    check("empty_rd_data_out", 32'(data_out), 32'h0);
    check("empty_rd_empty",    32'(empty_o),  32'h1);
    check("empty_rd_full",     32'(full_o),   32'h0);

    // Fill to FULL
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = fill_words[i];
      tick();
      check("fill_wr_ptr",   32'(wr_ptr),  32'(i + 1));
      check("fill_empty",    32'(empty_o), 32'h0);
      check("fill_full",     32'(full_o),  (i == 7) ? 32'h1 : 32'h0);
      check("fill_data_out", 32'(data_out), 32'h0);
    end
    check("fill_rd_ptr", 32'(rd_ptr), 32'h0);

    // Writes while FULL are dropped
    for (int i = 0; i < 3; i++) begin
      data_in = full_words[i];
      tick();
      check("full_wr_ptr", 32'(wr_ptr), 32'h8);
      check("full_full",   32'(full_o), 32'h1);
    end

    // Simultaneous read/write: first cycle only reads, then both proceed
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) data_in = 6'(6'h31 + i - 1);
      tick();
      check("rw_data_out", 32'(data_out), 32'(exp_rd[i]));
      check("rw_wr_ptr",   32'(wr_ptr),   (i == 0) ? 32'h8 : 32'((8 + i) % 16));
      check("rw_rd_ptr",   32'(rd_ptr),   32'((i + 1) % 16));
      check("rw_full",     32'(full_o),   32'h0);
      check("rw_empty",    32'(empty_o),  32'h0);
    end

    // Drain: remaining words 0x33..0x39, rd_ptr wraps 15 -> 0
    wr_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("drain_data_out", 32'(data_out), 32'(6'h33 + i));
      check("drain_rd_ptr",   32'((10 + i + 1) % 16), 32'(rd_ptr));
    end
    check("drain_empty",  32'(empty_o), 32'h1);
    check("drain_wr_ptr", 32'(wr_ptr),  32'h1);

    // Extra read after drain holds data_out
    tick();
    check("hold_data_out", 32'(data_out), 32'h39);
    check("hold_rd_ptr",   32'(rd_ptr),   32'h1);
    check("hold_empty",    32'(empty_o),  32'h1);

    // Partially refill, then reset asynchronously between edges
    rd_en = 1'b0;
    wr_en = 1'b1;
    data_in = 6'h0F;
    tick();
    tick();
    wr_en = 1'b0;
    check("refill_wr_ptr", 32'(wr_ptr),  32'h3);
    check("refill_empty",  32'(empty_o), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wr_ptr",   32'(wr_ptr),   32'h0);
    check("midrst_rd_ptr",   32'(rd_ptr),   32'h0);
    check("midrst_empty",    32'(empty_o),  32'h1);
    check("midrst_full",     32'(full_o),   32'h0);
    check("midrst_data_out", 32'(data_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_synchronous_fifo

`default_nettype wire
